keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce, change encoder and event FIFO
//
// Scans a 4x4 active-low key matrix one column at a time, debounces the
// whole 16-key map over several frames, and emits one event code per key
// whose debounced state changed into a 4-entry FIFO.
//
// Ports:
//   led_clk      clock
//   rst          synchronous active-high reset
//   row[3:0]     matrix rows, active-low, asynchronous to led_clk
//   col[3:0]     column drive, one-hot active-low
//   read_enable  pop strobe from the consumer
//   data[7:0]    FIFO head code: [7]=release, [3:0]=key index; 0x00 when empty
//   ready        FIFO non-empty
//   overflow     sticky, a code was dropped because the FIFO was full
//   key_down     at least one debounced key is pressed
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       led_clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       read_enable,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       key_down
);

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic {IDLE, ENCODE} enc_state_t;

  logic [3:0]      row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [15:0]     raw_q, raw_d, prev_q, prev_d, deb_q, deb_d, old_q, old_d;
  logic [DW-1:0]   stable_q, stable_d;
  enc_state_t      state_q, state_d;
  logic [3:0]      enc_k_q, enc_k_d;
  logic [3:0][7:0] mem_q, mem_d;
  logic [1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [2:0]      count_q, count_d;
  logic            ovf_q, ovf_d;

  logic        col_last, frame_end, commit;
  logic [15:0] raw_cur;
  logic        push, pop, full, accept, drop;
  logic [7:0]  code;

  always_comb begin
    row_s1_d  = row;
    row_s2_d  = row_s1_q;
    col_idx_d = col_idx_q;
    settle_d  = settle_q;
    raw_d     = raw_q;
    prev_d    = prev_q;
    deb_d     = deb_q;
    old_d     = old_q;
    stable_d  = stable_q;
    state_d   = state_q;
    enc_k_d   = enc_k_q;
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    code      = 8'h00;
    commit    = 1'b0;

    // Column scan: the last settle count of a column is its sampling cycle.
    col_last  = (settle_q == SW'(SETTLE_CYCLES));
    frame_end = col_last && (col_idx_q == 2'd3);
    if (col_last) begin
      settle_d  = '0;
      col_idx_d = col_idx_q + 2'd1;
    end else begin
      settle_d  = settle_q + SW'(1);
    end

    // Raw map including the column sampled this cycle, so the frame-end
    // comparison sees column 3 without waiting a cycle.
    raw_cur = raw_q;
    if (col_last) begin
      for (int r = 0; r < 4; r++) begin
        raw_cur[{2'(r), col_idx_q}] = ~row_s2_q[r];
      end
    end
    raw_d = raw_cur;

    if (frame_end) begin
      prev_d = raw_cur;
      if (raw_cur == prev_q) begin
        if (stable_q != DW'(DEBOUNCE_FRAMES)) stable_d = stable_q + DW'(1);
      end else begin
        stable_d = '0;
      end
      // Commit only on the transition into saturation, not while held there.
      commit = (stable_d == DW'(DEBOUNCE_FRAMES)) && (stable_q != DW'(DEBOUNCE_FRAMES));
    end
    if (commit) begin
      deb_d = raw_cur;
      old_d = deb_q;
    end

    // Encoder walks all 16 bits so the event order is always ascending k.
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = ENCODE;
          enc_k_d = 4'd0;
        end
      end
      ENCODE: begin
        if (deb_q[enc_k_q] != old_q[enc_k_q]) begin
          push = 1'b1;
          code = {old_q[enc_k_q], 3'b000, enc_k_q};
        end
        enc_k_d = enc_k_q + 4'd1;
        if (enc_k_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Event FIFO; a pop frees the slot for a same-cycle push when full.
    pop    = read_enable && (count_q != 3'd0);
    full   = (count_q == 3'd4);
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    if (pop) rd_d = rd_q + 2'd1;
    if (accept) begin
      mem_d[wr_q] = code;
      wr_d        = wr_q + 2'd1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (pop)       ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge led_clk) begin
    if (rst) begin
      row_s1_q  <= 4'b1111;
      row_s2_q  <= 4'b1111;
      col_idx_q <= 2'd0;
      settle_q  <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      old_q     <= '0;
      stable_q  <= '0;
      state_q   <= IDLE;
      enc_k_q   <= 4'd0;
      mem_q     <= '0;
      rd_q      <= 2'd0;
      wr_q      <= 2'd0;
      count_q   <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      col_idx_q <= col_idx_d;
      settle_q  <= settle_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      deb_q     <= deb_d;
      old_q     <= old_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      enc_k_q   <= enc_k_d;
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs are forced to their reset values while rst is high, even
  // before the first clock edge has cleared the registers.
  assign col      = rst ? 4'b1110 : ~(4'b0001 << col_idx_q);
  assign ready    = !rst && (count_q != 3'd0);
  assign data     = ready ? mem_q[rd_q] : 8'h00;
  assign overflow = !rst && ovf_q;
  assign key_down = !rst && (|deb_q);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with key-matrix model and code scoreboard
`timescale 1ns/1ps

module tb_keypad_scanner;

  logic       led_clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic       read_enable;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       key_down;

  logic [15:0] keys;
  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  keypad_scanner #(.SETTLE_CYCLES(3), .DEBOUNCE_FRAMES(8)) dut (
    .led_clk     (led_clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .read_enable (read_enable),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .key_down    (key_down)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  // Matrix model: a pressed key k = r*4+c pulls row r low while column c is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge led_clk);
    end
  endtask

  task automatic pop_one();
    read_enable = 1'b1;
    @(negedge led_clk);
    read_enable = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge led_clk);
    rst = 1'b1;
    @(negedge led_clk);
    n_checks++;
    if (col !== 4'b1110 || ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: col=%b ready=%b required col=1110 ready=0", col, ready);
    end
    rst = 1'b0;
    n_checks++;
    if (col !== 4'b1110 || ready !== 1'b0 || overflow !== 1'b0 || data !== 8'h00 || key_down !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: col=%b ready=%b ovf=%b data=%02h kd=%b required 1110/0/0/00/0",
               col, ready, overflow, data, key_down);
    end
    repeat (3) @(negedge led_clk);
    n_checks++;
    if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col0_hold: col=%b required 1110", col); end
    @(negedge led_clk);
    n_checks++;
    if (col !== 4'b1101) begin n_fail++; $display("FAIL reset_col1: col=%b required 1101", col); end
  endtask

  task automatic test_single_key();
    bit ok;
    logic [7:0] exp;
    keys[9] = 1'b1;
    exp_q.push_back(8'h09);
    wait_ready(1500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_press_timeout: ready=0 required 1"); end
    else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (data !== exp || key_down !== 1'b1) begin
        n_fail++; $display("FAIL single_press: data=%02h kd=%b required %02h kd=1", data, key_down, exp);
      end
      pop_one();
    end
    keys[9] = 1'b0;
    exp_q.push_back(8'h89);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single_release_timeout: no code, required %02h", exp); end
      else if (data !== exp || key_down !== 1'b0) begin
        n_fail++; $display("FAIL single_release: data=%02h kd=%b required %02h kd=0", data, key_down, exp);
      end
      if (ok) pop_one();
    end
  endtask

  task automatic test_bounce();
    bit ok;
    bit seen;
    logic [7:0] exp;
    for (int f = 0; f < 20; f++) begin
      keys[5] = ~keys[5];
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge led_clk);
        if (ready) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL bounce_no_push: frame %0d ready=1 required 0 data=%02h", f, data); end
    end
    keys[5] = 1'b1;
    exp_q.push_back(8'h05);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bounce_timeout: no code, required %02h", exp); end
      else if (data !== exp) begin n_fail++; $display("FAIL bounce_code: data=%02h required %02h", data, exp); end
      if (ok) pop_one();
    end
    seen = 1'b0;
    repeat (300) begin
      @(negedge led_clk);
      if (ready) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL bounce_single_event: extra code data=%02h required none", data); end
    keys[5] = 1'b0;
    exp_q.push_back(8'h85);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bounce_release_timeout: no code, required %02h", exp); end
      else if (data !== exp) begin n_fail++; $display("FAIL bounce_release: data=%02h required %02h", data, exp); end
      if (ok) pop_one();
    end
  endtask

  task automatic test_multi_key();
    bit ok;
    logic [7:0] exp;
    keys[3]  = 1'b1;
    keys[12] = 1'b1;
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h0C);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL multi_timeout: no code, required %02h", exp); end
      else if (data !== exp) begin n_fail++; $display("FAIL multi_press: data=%02h required %02h", data, exp); end
      if (ok) pop_one();
    end
    keys[3]  = 1'b0;
    keys[12] = 1'b0;
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h8C);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL multi_release_timeout: no code, required %02h", exp); end
      else if (data !== exp) begin n_fail++; $display("FAIL multi_release: data=%02h required %02h", data, exp); end
      if (ok) pop_one();
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] exp;
    int guard;
    keys[4:0] = 5'b11111;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
    wait_ready(1500, ok);
    repeat (24) @(negedge led_clk);
    n_checks++;
    if (!ok || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: ready_seen=%b overflow=%b required 1/1", ok, overflow);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL ovf_head: data=%02h required %02h", data, exp); end
    pop_one();
    n_checks++;
    if (overflow !== 1'b0 || data !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_clear: overflow=%b data=%02h required 0/%02h", overflow, data, exp_q[0]);
    end
    // Releasing all five keys pushes 0x80..0x84; with 3 queued, 0x81 arrives
    // while full, on the cycle after key_down is first seen low.
    keys[4:0] = 5'b00000;
    guard = 0;
    while (key_down && guard < 1500) begin
      @(negedge led_clk);
      guard++;
    end
    n_checks++;
    if (key_down) begin n_fail++; $display("FAIL ovf_release_timeout: key_down=1 required 0"); end
    @(negedge led_clk);
    pop_one();
    void'(exp_q.pop_front());
    n_checks++;
    if (overflow !== 1'b0 || data !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_push_pop_full: overflow=%b data=%02h required 0/%02h", overflow, data, exp_q[0]);
    end
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    repeat (20) @(negedge led_clk);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_resticky: overflow=%b required 1", overflow); end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_ready(50, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout: no code, required %02h", exp); end
      else if (data !== exp) begin n_fail++; $display("FAIL ovf_drain: data=%02h required %02h", data, exp); end
      if (ok) pop_one();
    end
    n_checks++;
    if (ready !== 1'b0 || overflow !== 1'b0 || data !== 8'h00) begin
      n_fail++; $display("FAIL ovf_empty: ready=%b overflow=%b data=%02h required 0/0/00", ready, overflow, data);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    bit seen;
    keys[0]  = 1'b1;
    keys[1]  = 1'b1;
    keys[2]  = 1'b1;
    keys[15] = 1'b1;
    guard = 0;
    while (!key_down && guard < 1500) begin
      @(negedge led_clk);
      guard++;
    end
    repeat (3) @(negedge led_clk);
    n_checks++;
    if (ready !== 1'b1 || key_down !== 1'b1) begin
      n_fail++; $display("FAIL midrst_setup: ready=%b kd=%b required 1/1", ready, key_down);
    end
    rst = 1'b1;
    @(negedge led_clk);
    n_checks++;
    if (ready !== 1'b0 || data !== 8'h00 || key_down !== 1'b0 || col !== 4'b1110) begin
      n_fail++;
      $display("FAIL midrst_state: ready=%b data=%02h kd=%b col=%b required 0/00/0/1110",
               ready, data, key_down, col);
    end
    keys = '0;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(negedge led_clk);
      if (ready || overflow) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midrst_stale: ready or overflow seen after reset, required none"); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    read_enable = 1'b0;
    keys        = '0;
    repeat (3) @(negedge led_clk);
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
